// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory controller.
// State encoding and default geometry of the data store.
package data_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage array.
// One synchronous write port and one registered read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only enable a port for in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr[IW-1:0]];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready requests, one-cycle responses,
// and a clear engine that walks the array after reset or on demand.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clear_req,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  state_t            state;
  logic [ADDR_W-1:0] clear_ptr;
  logic              rdata_zero;
  logic [DATA_W-1:0] arr_rdata;

  logic              accept;
  logic              in_range;
  logic              clr_last;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign req_ready = (state == ST_READY);
  assign init_busy = (state == ST_CLEAR);
  assign accept    = req_valid & req_ready;
  assign in_range  = 32'(req_addr) < 32'(DEPTH);
  assign clr_last  = clear_ptr == ADDR_W'(DEPTH - 1);

  // No request is accepted while clearing, so the port never collides.
  assign we    = init_busy | (accept & req_write & in_range);
  assign waddr = init_busy ? clear_ptr : req_addr;
  assign wdata = init_busy ? CLR_VAL : req_wdata;
  assign re    = accept & ~req_write & in_range;

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (req_addr),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_CLEAR;
      clear_ptr  <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & ~in_range;
      if (accept & ~req_write) begin
        rdata_zero <= ~in_range;
      end
      unique case (state)
        ST_CLEAR: begin
          if (clr_last) begin
            clear_ptr <= '0;
            state     <= ST_READY;
          end else begin
            clear_ptr <= clear_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (clear_req) begin
            state <= ST_CLEAR;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Zero flag covers reset and out-of-range reads without resetting the array.
  assign rsp_rdata = rdata_zero ? '0 : arr_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (DEPTH=200, CLR_VAL=A5).
// Reference model predicts readiness, responses and memory contents.
module tb_data_mem_ctrl;

  localparam int DEPTH = 200;
  localparam logic [7:0] CV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       init_busy;

  data_mem_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (8),
    .DEPTH   (DEPTH),
    .CLR_VAL (CV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .clear_req (clear_req),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  rsp_t       r;
  rsp_t       e;
  logic [7:0] ref_mem [256];
  int         clr_left = DEPTH;
  logic [7:0] last_rdata = 8'h00;
  bit         rdy;
  int         total = 0;
  int         bad = 0;

  task automatic fill();
    for (int i = 0; i < 256; i++) ref_mem[i] = CV;
  endtask

  // Reference model: advance at each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      clr_left = DEPTH;
      last_rdata = 8'h00;
      fill();
    end else begin
      rdy = (clr_left == 0);
      if (rdy && req_valid) begin
        r.err = int'(req_addr) >= DEPTH;
        if (req_write) begin
          if (!r.err) ref_mem[req_addr] = req_wdata;
          r.rdata = last_rdata;
        end else begin
          r.rdata = r.err ? 8'h00 : ref_mem[req_addr];
          last_rdata = r.rdata;
        end
        exp_q.push_back(r);
      end
      if (rdy && clear_req) begin
        fill();
        clr_left = DEPTH;
      end else if (clr_left > 0) begin
        clr_left = clr_left - 1;
      end
    end
  end

  // Monitor: compare outputs against the model at each falling edge.
  always @(negedge clk) begin
    total++;
    if (req_ready !== (clr_left == 0) || init_busy !== (clr_left != 0)) begin
      bad++;
      $display("FAIL ready: ready=%b busy=%b want_ready=%b t=%0t",
               req_ready, init_busy, clr_left == 0, $time);
    end
    if (rsp_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          bad++;
          $display("FAIL rsp: got rdata=%h err=%b want rdata=%h err=%b t=%0t",
                   rsp_rdata, rsp_err, e.rdata, e.err, $time);
        end
      end
    end else begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL missing_rsp: got rsp_valid=0 want 1 t=%0t", $time);
        exp_q.delete();
      end else if (rsp_rdata !== last_rdata) begin
        bad++;
        $display("FAIL rdata_hold: got %h want %h t=%0t",
                 rsp_rdata, last_rdata, $time);
      end
    end
  end

  task automatic step(input bit v, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input bit c);
    @(negedge clk);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    clear_req = c;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (clr_left == 0) break;
      idle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    clear_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Request held through the initial clear; exactly one acceptance.
    for (int i = 0; i < DEPTH + 10; i++) begin
      step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
      if (clr_left == 0) break;
    end
    idle();

    // Back-to-back write/read and range boundaries.
    step(1'b1, 1'b1, 8'h10, 8'h3C, 1'b0);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hC8, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 8'h12, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hC7, 8'h5E, 1'b0);
    step(1'b1, 1'b0, 8'hC7, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hC8, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    idle();

    // Write on the same edge as clear_req, then read back cleared value.
    step(1'b1, 1'b1, 8'h05, 8'h77, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    wait_ready();
    step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

    // Randomised traffic with occasional clears.
    repeat (700) begin
      step($urandom_range(0, 9) < 7,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'($urandom_range(0, 15)),
           8'($urandom),
           $urandom_range(0, 249) == 0);
    end
    idle();
    wait_ready();

    // Reset in the middle of a clear restarts it.
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (99) idle();
    do_reset();
    wait_ready();
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

    // Reset right after a response.
    step(1'b1, 1'b1, 8'h03, 8'h9A, 1'b0);
    step(1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
    do_reset();
    wait_ready();
    step(1'b1, 1'b0, 8'h03, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'hC7, 8'h00, 1'b0);
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised single-port data memory for the 8-bit CPU datapath.
- Uses a valid/ready request interface and a registered, one-cycle-latency response.
- After reset, or on command, a clear engine writes CLR_VAL into every entry, one entry per cycle, instead of a one-cycle array wipe.
- Sits between the CPU's MEM stage and the storage array; it is the successor to the flat 256x8 data memory.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 8: request address width in bits.
- DEPTH, 256: number of entries; legal range 2..2^ADDR_W.
- CLR_VAL, 0: value written to every entry during a clear (DATA_W bits).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- clear_req  in  1  start a full-array clear; sampled only in READY.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  DATA_W  read data; holds its value except when a read response is produced.
- rsp_err  out  1  address out of range; valid only with rsp_valid.
- init_busy  out  1  clear in progress.

Behaviour:
- Reset is asynchronous, active-high, with reset rst and clock clk.
- Reset values while rst is high:
  - state = CLEAR, clear_ptr = 0, init_busy = 1, req_ready = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - Array contents are not reset directly; the clear engine initialises them.
- FSM, two states:
  - CLEAR: each edge writes CLR_VAL to mem[clear_ptr], then clear_ptr++. The edge that writes entry DEPTH-1 moves the FSM to READY and sets clear_ptr = 0.
  - READY: requests are serviced.
- Clear timing: clearing all entries takes exactly DEPTH edges. Counting the first edge after rst falls as edge 1, init_busy = 0 and req_ready = 1 hold from edge DEPTH onward.
- req_ready = (state == READY). It is a registered-state decode with no combinational path from any input.
- Handshake:
  - A request is accepted on an edge where req_valid && req_ready.
  - Throughput is one request per cycle.
  - When req_ready = 0, req_valid is ignored, no response is produced, and the requester holds the request.
- Read accepted at edge N: after edge N, rsp_valid = 1 and rsp_rdata = mem[req_addr], sampled at edge N. rsp_valid drops after edge N+1 unless another request was accepted at N+1.
- Write accepted at edge N: mem[req_addr] = req_wdata at edge N, and rsp_valid = 1 after edge N. rsp_rdata is unchanged. A read accepted at N+1 to the same address returns the new data.
- Out-of-range address (req_addr >= DEPTH):
  - Reads: rsp_rdata = 0, rsp_err = 1.
  - Writes: array untouched, rsp_err = 1.
  - rsp_valid still pulses in both cases.
  - In-range accesses return rsp_err = 0.
- clear_req in READY:
  - At the edge where clear_req = 1 the FSM enters CLEAR, and req_ready = 0 from that edge.
  - If a request is accepted on the same edge, it completes normally: the write commits or the read captures pre-clear data, and its response still appears.
  - The clear then runs DEPTH edges and returns to READY.
- clear_req while in CLEAR is ignored; the clear does not restart.
- rst asserted mid-clear or mid-response behaves as full reset: the clear restarts from entry 0 and any pending rsp_valid is dropped.
- Address arithmetic:
  - clear_ptr has width ADDR_W, with the terminal compare against DEPTH-1, so DEPTH = 2^ADDR_W does not overflow.
  - req_addr is used unextended; no wrap-around is permitted.

Decomposition:
- Shared package data_mem_pkg holds:
  - the state enum (ST_CLEAR, ST_READY);
  - default parameter constants (DATA_W_DEF = 8, ADDR_W_DEF = 8, DEPTH_DEF = 256).
- Sub-module data_mem_array: DEPTH x DATA_W storage with one synchronous write port (we, waddr, wdata) and one synchronous read port. The top-level mux selects between the clear engine and the request path for the write port.
- FSM, clear pointer, range check and response registers live in data_mem_ctrl.

Test Plan:
- Reset with DEPTH=16, CLR_VAL=8'hA5, release rst -> init_busy=1 and req_ready=0 for edges 1..15; both flip at edge 16; reads of addresses 0..15 all return 8'hA5 with rsp_err=0.
- Default params: write 8'h3C to 8'h10, then read 8'h10 on the next cycle back-to-back -> rsp_valid on 2 consecutive cycles; second response rsp_rdata=8'h3C.
- DEPTH=200: read 8'hC8 and write 8'hFF -> both responses have rsp_err=1; read rsp_rdata=0; a follow-up read of 8'h00 is unaffected.
- Write 8'h77 to 8'h05 on the same edge as clear_req (CLR_VAL=0) -> write response pulses; req_ready=0 for 256 cycles; then read 8'h05 returns 8'h00.
- Assert rst at clear edge 100, release -> clear restarts; init_busy is held for a full 256 edges after release, and no rsp_valid appears during the clear.
- Hold req_valid=1 with a read of 8'h01 while init_busy=1 -> no rsp_valid until READY; exactly one response follows the accepting edge.
